// File: rtl/ram_arb_pkg.sv
// Shared types for the single-port data RAM arbiter.
// The optional lock feature in the top is enabled by defining RAM_ARB_LOCK_EN.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_EXT  = 1'b1
    } owner_t;

    // Wait counter width; WAIT_STATES is limited to 1..15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin picker: a lone requester wins outright; on a tie the
// requester that did not own the RAM last time wins.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output owner_t     gnt_owner,
    output logic       gnt_vld
);

    always_comb begin
        gnt_vld   = |req;
        gnt_owner = OWN_CORE;
        case (req)
            2'b10:   gnt_owner = OWN_EXT;
            2'b11:   gnt_owner = (last_owner == OWN_CORE) ? OWN_EXT : OWN_CORE;
            default: gnt_owner = OWN_CORE;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates the single-port data RAM between the core and an external port.
// Define RAM_ARB_LOCK_EN to add c_lock, which holds the RAM for the core across accesses.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
`ifdef RAM_ARB_LOCK_EN
    input  logic              c_lock,
`endif
    output logic              c_gnt,
    output logic              c_done,
    output logic [DATA_W-1:0] c_rdata,
    input  logic              e_req,
    input  logic              e_wr,
    input  logic [ADDR_W-1:0] e_addr,
    input  logic [DATA_W-1:0] e_wdata,
    output logic              e_gnt,
    output logic              e_done,
    output logic [DATA_W-1:0] e_rdata,
    output logic              ram_cs,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    state_t            state;
    owner_t            owner_q;
    owner_t            last_owner;
    logic              wr_q;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        arb_req;
    owner_t            pick_owner;
    logic              pick_vld;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef RAM_ARB_LOCK_EN
    logic lock_q;
    // A locked core keeps the external side out of arbitration entirely.
    assign arb_req = {e_req & ~lock_q, c_req};
`else
    assign arb_req = {e_req, c_req};
`endif

    ram_arb_rr u_rr (
        .req        (arb_req),
        .last_owner (last_owner),
        .gnt_owner  (pick_owner),
        .gnt_vld    (pick_vld)
    );

    assign sel_wr    = (pick_owner == OWN_CORE) ? c_wr    : e_wr;
    assign sel_addr  = (pick_owner == OWN_CORE) ? c_addr  : e_addr;
    assign sel_wdata = (pick_owner == OWN_CORE) ? c_wdata : e_wdata;

    // The ram_addr/ram_wdata registers double as the latched operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_q    <= OWN_CORE;
            last_owner <= OWN_EXT;
            wr_q       <= 1'b0;
            cnt        <= '0;
            c_gnt      <= 1'b0;
            c_done     <= 1'b0;
            c_rdata    <= '0;
            e_gnt      <= 1'b0;
            e_done     <= 1'b0;
            e_rdata    <= '0;
            ram_cs     <= 1'b0;
            ram_rd     <= 1'b0;
            ram_wr     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
`ifdef RAM_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            c_gnt  <= 1'b0;
            e_gnt  <= 1'b0;
            c_done <= 1'b0;
            e_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state     <= ACCESS;
                        owner_q   <= pick_owner;
                        wr_q      <= sel_wr;
                        cnt       <= CNT_W'(WAIT_STATES - 1);
                        c_gnt     <= (pick_owner == OWN_CORE);
                        e_gnt     <= (pick_owner == OWN_EXT);
                        ram_cs    <= 1'b1;
                        ram_rd    <= ~sel_wr;
                        ram_wr    <= sel_wr;
                        ram_addr  <= sel_addr;
                        ram_wdata <= sel_wdata;
                        busy      <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state     <= DONE;
                        ram_cs    <= 1'b0;
                        ram_rd    <= 1'b0;
                        ram_wr    <= 1'b0;
                        ram_addr  <= '0;
                        ram_wdata <= '0;
                        last_owner <= owner_q;
                        if (owner_q == OWN_CORE) begin
                            c_done <= 1'b1;
                            if (!wr_q) c_rdata <= ram_rdata;
`ifdef RAM_ARB_LOCK_EN
                            lock_q <= c_lock;
`endif
                        end else begin
                            e_done <= 1'b1;
                            if (!wr_q) e_rdata <= ram_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // Turnaround cycle: strobes already low, done pulse visible.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
